ad7886_sampler: RTL

Sampling controller for the AD7886 12-bit ADC on the transmit board, clocked from the 16 MHz PLL output. Holds off until the PLL reports lock, then triggers conversions at a fixed rate (default 32 kHz), waits for the converter's BUSY to clear, and reads the parallel result. Each sample is delivered to the downstream 2PSK modulator as a one-cycle valid pulse.

---
 rtl/ad7886_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/ad7886_sampler.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ad7886_pkg.sv
// Shared types and defaults for the AD7886 sampling controller.
package ad7886_pkg;

    localparam int ADC_W            = 12;
    localparam int CLK_DIV_DEF      = 500;
    localparam int CONVST_LOW_DEF   = 4;
    localparam int RD_LOW_DEF       = 4;
    localparam int BUSY_TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CONVST    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_READ      = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    // Offset-binary to two's complement is a plain MSB inversion.
    function automatic logic [ADC_W-1:0] fmt_sample(input logic [ADC_W-1:0] raw,
                                                    input logic             twos);
        return twos ? {~raw[ADC_W-1], raw[ADC_W-2:0]} : raw;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous status inputs.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ad7886_sampler.sv
// AD7886 sampling controller: rate generator, conversion/read sequencer,
// BUSY timeout and overrun accounting. All outputs come straight from flops.
module ad7886_sampler
    import ad7886_pkg::*;
#(
    parameter int CLK_DIV      = CLK_DIV_DEF,
    parameter int CONVST_LOW   = CONVST_LOW_DEF,
    parameter int RD_LOW       = RD_LOW_DEF,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
    parameter bit TWOS_COMP    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             enable,
    input  logic             adc_busy,
    input  logic [ADC_W-1:0] adc_db,
    output logic             adc_convst_n,
    output logic             adc_cs_n,
    output logic             adc_rd_n,
    output logic [ADC_W-1:0] sample_data,
    output logic             sample_valid,
    output logic             timeout_err,
    output logic [7:0]       overrun_cnt
);

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] CONV_LAST = 16'(CONVST_LOW - 1);
    localparam logic [15:0] RD_LAST   = 16'(RD_LOW - 1);
    localparam logic [15:0] TMO_LAST  = 16'(BUSY_TIMEOUT - 1);

    logic lock_s;
    logic busy_s;
    logic run_s;
    logic tick_s;
    logic capture_s;

    state_e           state_q, state_d;
    logic [15:0]      rate_q, rate_d;
    logic [15:0]      phase_q, phase_d;
    logic [15:0]      tmo_q, tmo_d;
    logic             seen_q, seen_d;
    logic             timeout_q, timeout_d;
    logic [7:0]       ovr_q, ovr_d;
    logic             convst_n_q, cs_n_q, rd_n_q, valid_q;
    logic [ADC_W-1:0] data_q;

    sync_2ff u_sync_lock (.clk(clk), .rst_n(rst_n), .d_i(pll_locked), .q_o(lock_s));
    sync_2ff u_sync_busy (.clk(clk), .rst_n(rst_n), .d_i(adc_busy),   .q_o(busy_s));

    assign run_s  = lock_s & enable;
    assign tick_s = run_s && (rate_q == DIV_LAST);

    // Rate counter next state and overrun accounting.
    always_comb begin
        rate_d = 16'd0;
        ovr_d  = ovr_q;
        if (run_s && !tick_s) begin
            rate_d = rate_q + 16'd1;
        end else begin
            rate_d = 16'd0;
        end
        if (tick_s && (state_q != ST_IDLE) && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // Sequencer next state; losing lock or enable aborts to IDLE from anywhere.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q + 16'd1;
        tmo_d     = tmo_q;
        seen_d    = seen_q;
        timeout_d = timeout_q;
        capture_s = 1'b0;
        if (!run_s) begin
            state_d = ST_IDLE;
            phase_d = 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    phase_d = 16'd0;
                    if (tick_s) state_d = ST_CONVST;
                    else        state_d = ST_IDLE;
                end
                ST_CONVST: begin
                    if (phase_q == CONV_LAST) begin
                        state_d = ST_WAIT_BUSY;
                        phase_d = 16'd0;
                        tmo_d   = 16'd0;
                        seen_d  = 1'b0;
                    end else begin
                        state_d = ST_CONVST;
                    end
                end
                ST_WAIT_BUSY: begin
                    tmo_d   = tmo_q + 16'd1;
                    phase_d = 16'd0;
                    if (busy_s) seen_d = 1'b1;
                    else        seen_d = seen_q;
                    // A completed conversion wins over a simultaneous timeout.
                    if (seen_q && !busy_s) begin
                        state_d = ST_READ;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d   = ST_IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT_BUSY;
                    end
                end
                ST_READ: begin
                    if (phase_q == RD_LAST) begin
                        state_d   = ST_DONE;
                        capture_s = 1'b1;
                    end else begin
                        state_d = ST_READ;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    phase_d = 16'd0;
                end
                default: begin
                    state_d = ST_IDLE;
                    phase_d = 16'd0;
                end
            endcase
        end
    end

    // State, counters and outputs; strobes decode the next state so each is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rate_q     <= 16'd0;
            phase_q    <= 16'd0;
            tmo_q      <= 16'd0;
            seen_q     <= 1'b0;
            timeout_q  <= 1'b0;
            ovr_q      <= 8'd0;
            convst_n_q <= 1'b1;
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            valid_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            rate_q     <= rate_d;
            phase_q    <= phase_d;
            tmo_q      <= tmo_d;
            seen_q     <= seen_d;
            timeout_q  <= timeout_d;
            ovr_q      <= ovr_d;
            convst_n_q <= (state_d != ST_CONVST);
            cs_n_q     <= (state_d != ST_READ);
            rd_n_q     <= (state_d != ST_READ);
            valid_q    <= (state_d == ST_DONE);
            if (capture_s) data_q <= fmt_sample(adc_db, TWOS_COMP);
        end
    end

    assign adc_convst_n = convst_n_q;
    assign adc_cs_n     = cs_n_q;
    assign adc_rd_n     = rd_n_q;
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign timeout_err  = timeout_q;
    assign overrun_cnt  = ovr_q;

endmodule
